key_matrix_scanner: RTL and testbench
=====================================

Name: key_matrix_scanner

Overview:
- Input-side counterpart of the multiplexed LED display driver: strobes the columns of a 4x4 push-button matrix, reads the returned row lines, debounces each key and emits press/release events.
- Events go through a 4-entry FIFO with a valid/ready handshake.
- Sits between the front-panel buttons and the clock-setting control logic.

Parameters:
- CLK_RATE_HZ, 390625, input clock frequency.
- SCAN_RATE_HZ, 1000, column-step rate. TICK_DIV = CLK_RATE_HZ/(SCAN_RATE_HZ*4), default 97. TICK_DIV < 8 is a configuration error and the sim assertion fires.
- DEBOUNCE_SCANS, 4, consecutive disagreeing samples (one per frame) needed to flip a key's debounced state. Must be at least 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- col_strobe  out  4  one-hot column drive, active high
- row_in  in  4  row return lines, active high (pulled down externally), asynchronous
- key_code  out  4  event key index = col*4+row
- key_pressed  out  1  event type: 1 = press, 0 = release
- key_valid  out  1  FIFO head valid
- key_ready  in  1  consumer accepts the head
- key_state  out  16  debounced level of every key
- overflow  out  1  sticky: an event was dropped
- clear_overflow  in  1  clears overflow

Behaviour:
- Reset (async, reset_n=0), all regs cleared immediately:
  - col_strobe=4'b0001, key_valid=0, key_code=0, key_pressed=0, key_state=0, overflow=0.
  - FIFO empty, debounce counters 0, divider 0, FSM=SCAN.
- row_in passes through a 2-flop synchronizer; only synced rows are used.
- Divider counts 0..TICK_DIV-1 and wraps. Each column is driven for exactly TICK_DIV cycles. Frame = 4*TICK_DIV cycles.
- FSM states:
  - SCAN: when divider==TICK_DIV-1, capture synced rows into sample[3:0], latch col_idx=current column, rotate col_strobe left (0b1000 wraps to 0b0001) on the same edge, go to UPD0.
  - UPD0..UPD3: one clock each; UPDn processes key k=col_idx*4+n against sample[n]. UPD3 returns to SCAN. The update sequence (4 cycles) completes before the next capture because TICK_DIV >= 8.
- Per-key debounce (16 counters, width clog2(DEBOUNCE_SCANS+1)):
  - sample == key_state[k]: counter := 0.
  - Otherwise counter += 1. When the new value equals DEBOUNCE_SCANS: key_state[k] := sample, counter := 0, event {sample, k} generated.
- Event latency: a change is reported after DEBOUNCE_SCANS frames of stable contrary samples.
- FIFO (4 entries x 5 bits {pressed, code}):
  - Write happens in the UPD cycle that generated the event.
  - key_valid = not empty, registered. It rises the cycle after the write into an empty FIFO.
  - Pop when key_valid & key_ready.
  - While key_valid=1 & key_ready=0, key_code and key_pressed hold stable.
  - Simultaneous push and pop when full: allowed, no drop.
  - Push when full with no pop: event dropped, overflow := 1; key_state still updates.
- overflow stays set until clear_overflow=1. If clear_overflow and a drop coincide, overflow stays 1 (set wins).
- Several keys in one column changing at once produce events in row order on consecutive UPD cycles, i.e. ascending code.
- Ghosting (3+ keys forming a rectangle) is not suppressed; the raw matrix reading is reported as-is.

Test Plan:
- Run all scenarios with CLK_RATE_HZ=32000, SCAN_RATE_HZ=1000 (TICK_DIV=8, frame=32), DEBOUNCE_SCANS=3.
- Reset: hold reset_n=0 -> col_strobe=0001, key_valid=0, key_state=0, overflow=0. Release -> col_strobe steps 0001→0010→0100→1000→0001, each for 8 cycles.
- Single key: row_in[1]=1 whenever col_strobe=0100, held 10 frames, key_ready=1 -> exactly one event {pressed=1, code=9}, key_state[9]=1 after the 3rd sample. Row released -> one event {0, 9} and key_state[9]=0 three frames later.
- Bounce: key 9 pressed for 2 frames, released 1 frame, repeated 5 times -> no event, key_state[9] stays 0.
- Same-column burst plus overflow: key_ready=0, rows 0..3 all active on column 1 -> FIFO holds codes 4,5,6,7 (pressed=1). Then press key 0 -> overflow=1, key_state[0]=1. Pop all four and verify order 4,5,6,7. Pulse clear_overflow -> overflow=0.
- Backpressure: with key_valid=1, key_ready=0 for 50 cycles -> key_code and key_pressed are constant. Set key_ready=1 for one cycle -> exactly one pop.
- Reset mid-operation: assert reset_n=0 during UPD2 with 2 events queued -> FIFO empties and key_state=0 in the same cycle. After release -> col_strobe=0001, no stale events.

Source files
------------

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner
//   Scans a 4x4 push-button matrix one column at a time. It debounces every
//   key with its own counter and queues press/release events in a 4-deep FIFO.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   col_strobe     one-hot column drive, active high
//   row_in         row return lines, active high, asynchronous to clk
//   key_code       FIFO head: key index = col*4 + row
//   key_pressed    FIFO head: 1 = press, 0 = release
//   key_valid      FIFO not empty
//   key_ready      consumer takes the head when key_valid is high
//   key_state      debounced level of all 16 keys
//   overflow       sticky flag: an event was dropped because the FIFO was full
//   clear_overflow clears overflow (a drop in the same cycle wins)
//
// FSM states
//   state    | meaning
//   ST_SCAN  | drive current column, wait for end of column slot
//   ST_UPD0  | debounce key col*4+0 against captured row 0
//   ST_UPD1  | debounce key col*4+1 against captured row 1
//   ST_UPD2  | debounce key col*4+2 against captured row 2
//   ST_UPD3  | debounce key col*4+3 against captured row 3, back to scan
module key_matrix_scanner #(
    parameter int CLK_RATE_HZ    = 390625,
    parameter int SCAN_RATE_HZ   = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [3:0]  col_strobe,
    input  logic [3:0]  row_in,
    output logic [3:0]  key_code,
    output logic        key_pressed,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [15:0] key_state,
    output logic        overflow,
    input  logic        clear_overflow
);
    localparam int TICK_DIV = CLK_RATE_HZ / (SCAN_RATE_HZ * 4);
    localparam int DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W    = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [2:0] {
        ST_SCAN = 3'd0,
        ST_UPD0 = 3'd1,
        ST_UPD1 = 3'd2,
        ST_UPD2 = 3'd3,
        ST_UPD3 = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              row_meta_q, row_meta_d;
    logic [3:0]              row_sync_q, row_sync_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [3:0]              col_strobe_q, col_strobe_d;
    logic [3:0]              sample_q, sample_d;
    logic [1:0]              col_idx_q, col_idx_d;
    logic [15:0]             key_state_q, key_state_d;
    logic [15:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0][4:0]         fifo_mem_q, fifo_mem_d;
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [2:0]              fifo_cnt_q, fifo_cnt_d;
    logic                    key_valid_q, key_valid_d;
    logic                    overflow_q, overflow_d;

    logic                    tick;
    logic [1:0]              col_now;
    logic                    upd_en;
    logic [1:0]              upd_row;
    logic [3:0]              upd_key;
    logic                    upd_sample;
    logic [CNT_W-1:0]        upd_cnt_inc;
    logic                    ev_push;
    logic [4:0]              ev_data;
    logic                    pop;
    logic                    full;
    logic                    push_ok;
    logic                    drop;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        row_meta_d   = row_in;
        row_sync_d   = row_meta_q;
        div_d        = tick ? '0 : div_q + DIV_W'(1);
        col_strobe_d = col_strobe_q;
        state_d      = state_q;
        sample_d     = sample_q;
        col_idx_d    = col_idx_q;
        key_state_d  = key_state_q;
        cnt_d        = cnt_q;
        upd_en       = 1'b0;
        upd_row      = 2'd0;
        ev_push      = 1'b0;
        ev_data      = 5'd0;

        case (col_strobe_q)
            4'b0010: col_now = 2'd1;
            4'b0100: col_now = 2'd2;
            4'b1000: col_now = 2'd3;
            default: col_now = 2'd0;
        endcase

        // Column rotation is tied to the divider alone so every column gets
        // exactly TICK_DIV cycles regardless of FSM activity.
        if (tick) begin
            col_strobe_d = {col_strobe_q[2:0], col_strobe_q[3]};
        end

        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    sample_d  = row_sync_q;
                    col_idx_d = col_now;
                    state_d   = ST_UPD0;
                end
            end
            ST_UPD0: begin upd_en = 1'b1; upd_row = 2'd0; state_d = ST_UPD1; end
            ST_UPD1: begin upd_en = 1'b1; upd_row = 2'd1; state_d = ST_UPD2; end
            ST_UPD2: begin upd_en = 1'b1; upd_row = 2'd2; state_d = ST_UPD3; end
            ST_UPD3: begin upd_en = 1'b1; upd_row = 2'd3; state_d = ST_SCAN; end
            default: state_d = ST_SCAN;
        endcase

        upd_key     = {col_idx_q, upd_row};
        upd_sample  = sample_q[upd_row];
        upd_cnt_inc = cnt_q[upd_key] + CNT_W'(1);

        if (upd_en) begin
            if (upd_sample == key_state_q[upd_key]) begin
                cnt_d[upd_key] = '0;
            end else if (upd_cnt_inc == CNT_TRIP) begin
                key_state_d[upd_key] = upd_sample;
                cnt_d[upd_key]       = '0;
                ev_push              = 1'b1;
                ev_data              = {upd_sample, upd_key};
            end else begin
                cnt_d[upd_key] = upd_cnt_inc;
            end
        end

        // A pop frees the slot being written, so a full FIFO still accepts
        // a push in the same cycle.
        pop     = key_valid_q & key_ready;
        full    = (fifo_cnt_q == 3'd4);
        push_ok = ev_push & (~full | pop);
        drop    = ev_push & full & ~pop;

        fifo_mem_d = fifo_mem_q;
        if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = ev_data;
        end
        wr_ptr_d = push_ok ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;

        case ({push_ok, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        key_valid_d = (fifo_cnt_d != 3'd0);

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SCAN;
            row_meta_q   <= '0;
            row_sync_q   <= '0;
            div_q        <= '0;
            col_strobe_q <= 4'b0001;
            sample_q     <= '0;
            col_idx_q    <= '0;
            key_state_q  <= '0;
            cnt_q        <= '0;
            fifo_mem_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            key_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_meta_q   <= row_meta_d;
            row_sync_q   <= row_sync_d;
            div_q        <= div_d;
            col_strobe_q <= col_strobe_d;
            sample_q     <= sample_d;
            col_idx_q    <= col_idx_d;
            key_state_q  <= key_state_d;
            cnt_q        <= cnt_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            key_valid_q  <= key_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // The four update cycles must finish before the next column capture.
    always_ff @(posedge clk) begin
        assert (TICK_DIV >= 8) else $error("key_matrix_scanner: TICK_DIV must be at least 8");
        assert (DEBOUNCE_SCANS >= 1) else $error("key_matrix_scanner: DEBOUNCE_SCANS must be at least 1");
    end

    assign col_strobe  = col_strobe_q;
    assign key_code    = fifo_mem_q[rd_ptr_q][3:0];
    assign key_pressed = fifo_mem_q[rd_ptr_q][4];
    assign key_valid   = key_valid_q;
    assign key_state   = key_state_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
module tb_key_matrix_scanner;
    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  col_strobe;
    logic [3:0]  row_in;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] key_state;
    logic        overflow;
    logic        clear_overflow;

    logic [15:0] btn;
    int          vectors = 0;
    int          miscompares = 0;
    int          pcnt;
    logic        rdy_e, clr_e;
    logic [15:0] btn_e;

    key_matrix_scanner #(
        .CLK_RATE_HZ(32000),
        .SCAN_RATE_HZ(1000),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .col_strobe(col_strobe),
        .row_in(row_in),
        .key_code(key_code),
        .key_pressed(key_pressed),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_state(key_state),
        .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    // Passive switch matrix: a pressed key connects its column to its row.
    assign row_in = ({4{col_strobe[0]}} & btn[3:0])  | ({4{col_strobe[1]}} & btn[7:4]) |
                    ({4{col_strobe[2]}} & btn[11:8]) | ({4{col_strobe[3]}} & btn[15:12]);

    // Clock edges seen since reset release; edge q ends cycle q-1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pcnt <= 0;
        else          pcnt <= pcnt + 1;
    end

    always @(posedge clk) begin
        rdy_e <= key_ready;
        clr_e <= clear_overflow;
        btn_e <= btn;
    end

    // Model: frame of 32 cycles, column c captured at edge 8*(c+1) mod 32,
    // row n of that column resolved n+1 edges later.
    logic [15:0] m_state;
    int          m_cnt[16];
    logic [4:0]  m_fifo[$];
    logic        m_ovf;
    logic [3:0]  m_snap;
    int          m_snap_col;
    bit          m_snap_ok;
    int          m_q;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = '0;
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_fifo.delete();
        m_ovf     = 1'b0;
        m_snap    = '0;
        m_snap_col = 0;
        m_snap_ok = 1'b0;
        m_q       = 0;
    endtask

    task automatic model_step(int q);
        int         n, k;
        logic       s;
        bit         ev, drop;
        logic [4:0] evd;
        ev = 1'b0; drop = 1'b0; evd = '0;
        if (q % 8 == 0) begin
            m_snap_col = ((q - 1) / 8) % 4;
            m_snap     = btn_e[m_snap_col*4 +: 4];
            m_snap_ok  = 1'b1;
        end else if (q % 8 <= 4 && m_snap_ok) begin
            n = q % 8 - 1;
            k = m_snap_col * 4 + n;
            s = m_snap[n];
            if (s == m_state[k]) begin
                m_cnt[k] = 0;
            end else begin
                m_cnt[k]++;
                if (m_cnt[k] == DEB) begin
                    m_state[k] = s;
                    m_cnt[k]   = 0;
                    ev         = 1'b1;
                    evd        = {s, 4'(k)};
                end
            end
        end
        if (m_fifo.size() != 0 && rdy_e) void'(m_fifo.pop_front());
        if (ev) begin
            if (m_fifo.size() < 4) m_fifo.push_back(evd);
            else drop = 1'b1;
        end
        if (drop)       m_ovf = 1'b1;
        else if (clr_e) m_ovf = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                model_reset();
                chk("rst_col_strobe", col_strobe, 16'h1);
                chk("rst_key_valid", key_valid, 16'h0);
                chk("rst_key_state", key_state, 16'h0);
                chk("rst_overflow", overflow, 16'h0);
                chk("rst_key_code", key_code, 16'h0);
                chk("rst_key_pressed", key_pressed, 16'h0);
            end else begin
                if (pcnt != m_q) begin
                    m_q = pcnt;
                    model_step(m_q);
                end
                chk("col_strobe", col_strobe, 16'(1 << ((m_q / 8) % 4)));
                chk("key_state", key_state, m_state);
                chk("key_valid", key_valid, 16'(m_fifo.size() != 0));
                chk("overflow", overflow, 16'(m_ovf));
                if (m_fifo.size() != 0) begin
                    chk("key_code", key_code, 16'(m_fifo[0][3:0]));
                    chk("key_pressed", key_pressed, 16'(m_fifo[0][4]));
                end
            end
        end
    end

    // Advance to 2 time units after the edge that makes pcnt == target.
    task automatic go_to(int target);
        int guard;
        guard = 0;
        while (pcnt < target) begin
            @(posedge clk);
            #2;
            guard++;
            if (guard > 20000) begin
                miscompares++;
                $display("FAIL go_to: reached %0d expected %0d", pcnt, target);
                break;
            end
        end
    endtask

    task automatic pop_one();
        key_ready = 1'b1;
        @(posedge clk);
        #2;
        key_ready = 1'b0;
    endtask

    initial begin
        int qs[8];
        logic [3:0] cs[8];
        qs = '{7, 8, 15, 16, 23, 24, 31, 32};
        cs = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};

        reset_n = 1'b1; btn = '0; key_ready = 1'b0; clear_overflow = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_col", col_strobe, 16'h1);
        chk("lit_rst_valid", key_valid, 16'h0);
        chk("lit_rst_state", key_state, 16'h0);
        chk("lit_rst_ovf", overflow, 16'h0);
        #1 reset_n = 1'b1;

        // column stepping, 8 cycles per column
        for (int i = 0; i < 8; i++) begin
            go_to(qs[i]);
            chk("lit_col_step", col_strobe, 16'(cs[i]));
        end

        // single key 9 press then release
        key_ready = 1'b1;
        go_to(33);  btn[9] = 1'b1;
        go_to(121); chk("lit_k9_before", key_state[9], 16'h0);
        go_to(122); chk("lit_k9_set", key_state[9], 16'h1);
                    chk("lit_k9_valid", key_valid, 16'h1);
                    chk("lit_k9_code", key_code, 16'h9);
                    chk("lit_k9_press", key_pressed, 16'h1);
        go_to(123); chk("lit_k9_popped", key_valid, 16'h0);
        go_to(353); btn[9] = 1'b0;
        go_to(441); chk("lit_k9_still", key_state[9], 16'h1);
        go_to(442); chk("lit_k9_clr", key_state[9], 16'h0);
                    chk("lit_k9_rel_valid", key_valid, 16'h1);
                    chk("lit_k9_rel_code", key_code, 16'h9);
                    chk("lit_k9_rel_press", key_pressed, 16'h0);

        // bounce: 2 frames pressed, 1 released, 5 times
        for (int i = 0; i < 5; i++) begin
            go_to(449 + 96 * i);      btn[9] = 1'b1;
            go_to(449 + 96 * i + 64); btn[9] = 1'b0;
        end
        go_to(929);
        chk("lit_bounce_state", key_state[9], 16'h0);
        chk("lit_bounce_valid", key_valid, 16'h0);

        // same-column burst then overflow
        key_ready = 1'b0;
        btn[7:4] = 4'hF;
        go_to(1012); chk("lit_burst_head", key_code, 16'h4);
        go_to(1017); btn[0] = 1'b1;
        go_to(1096); chk("lit_ovf_before", overflow, 16'h0);
        go_to(1097); chk("lit_ovf_set", overflow, 16'h1);
                     chk("lit_ovf_k0", key_state[0], 16'h1);
                     chk("lit_burst_state", key_state[7:4], 16'hF);
        for (int i = 0; i < 4; i++) begin
            chk("lit_burst_code", key_code, 16'(4 + i));
            chk("lit_burst_press", key_pressed, 16'h1);
            chk("lit_burst_valid", key_valid, 16'h1);
            pop_one();
        end
        chk("lit_burst_empty", key_valid, 16'h0);
        chk("lit_ovf_sticky", overflow, 16'h1);
        clear_overflow = 1'b1;
        @(posedge clk); #2;
        clear_overflow = 1'b0;
        chk("lit_ovf_cleared", overflow, 16'h0);

        // backpressure: two release events, hold 50 cycles, pop one
        go_to(1121); btn[4] = 1'b0; btn[5] = 1'b0;
        go_to(1203);
        for (int i = 0; i < 50; i++) begin
            chk("lit_bp_code", key_code, 16'h4);
            chk("lit_bp_press", key_pressed, 16'h0);
            chk("lit_bp_valid", key_valid, 16'h1);
            @(posedge clk); #2;
        end
        pop_one();
        chk("lit_bp_next_code", key_code, 16'h5);
        chk("lit_bp_next_valid", key_valid, 16'h1);
        chk("lit_bp_next_press", key_pressed, 16'h0);
        pop_one();
        chk("lit_bp_empty", key_valid, 16'h0);

        // reset during UPD2 with two events queued
        go_to(1257); btn[6] = 1'b0; btn[7] = 1'b0;
        go_to(1333); chk("lit_pre_rst_valid", key_valid, 16'h1);
                     chk("lit_pre_rst_code", key_code, 16'h6);
        go_to(1338);
        reset_n = 1'b0;
        #1;
        chk("lit_mid_rst_valid", key_valid, 16'h0);
        chk("lit_mid_rst_state", key_state, 16'h0);
        chk("lit_mid_rst_col", col_strobe, 16'h1);
        chk("lit_mid_rst_code", key_code, 16'h0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        go_to(40); chk("lit_post_rst_valid", key_valid, 16'h0);
        go_to(72); chk("lit_post_rst_valid2", key_valid, 16'h0);
        go_to(73); chk("lit_post_rst_ev_valid", key_valid, 16'h1);
                   chk("lit_post_rst_ev_code", key_code, 16'h0);
                   chk("lit_post_rst_ev_press", key_pressed, 16'h1);
                   chk("lit_post_rst_state", key_state, 16'h0001);
        key_ready = 1'b1;
        btn = '0;
        go_to(300);
        chk("lit_end_state", key_state, 16'h0);
        chk("lit_end_valid", key_valid, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
